ball_vertical_engine: RTL

//  Parametrised vertical ball-motion unit: holds ball Y position and signed Y velocity,

---
 rtl/ball_vertical_engine_pkg.sv | 12 +
 rtl/ball_vertical_engine_velocity.sv | 31 +++
 rtl/ball_vertical_engine.sv | 72 +++++++
 3 files changed

// File: rtl/ball_vertical_engine_pkg.sv
// ball_vertical_engine_pkg: playfield defaults and paddle-segment velocity table
package ball_vertical_engine_pkg;
    localparam int V_TOP_D     = 16;
    localparam int V_BOTTOM_D  = 256;
    localparam int BALL_H_D    = 4;
    localparam int SERVE_Y_D   = 128;
    localparam int MAX_SPEED_D = 3;
    localparam int SEG_VEL [8] = '{-3, -2, -1, 0, 0, 1, 2, 3};
    function automatic int clamp_vel(input int v, input int m);
        return v > m ? m : (v < -m ? -m : v);
    endfunction
endpackage

// File: rtl/ball_vertical_engine_velocity.sv
// ball_vertical_engine_velocity: paddle-hit latch holding the velocity to apply at the next frame
module ball_vertical_engine_velocity
    import ball_vertical_engine_pkg::*;
#(
    parameter int VEL_BITS  = 4,
    parameter int MAX_SPEED = MAX_SPEED_D
) (
    input  logic                       clk,
    input  logic                       _reset,
    input  logic                       hit,
    input  logic [2:0]                 hit_seg,
    input  logic                       attract,
    input  logic                       frame_ce,
    input  logic                       serve,
    output logic                       pend,
    output logic signed [VEL_BITS-1:0] vel_next
);
    logic take;
    assign take = hit && !attract;
    // a hit coinciding with frame_ce survives the frame clear and is used next frame
    always_ff @(posedge clk) begin
        if (!_reset) begin
            pend     <= 1'b0;
            vel_next <= '0;
        end else begin
            if (take)
                vel_next <= VEL_BITS'(clamp_vel(SEG_VEL[hit_seg], MAX_SPEED));
            pend <= serve ? 1'b0 : take ? 1'b1 : frame_ce ? 1'b0 : pend;
        end
    end
endmodule

// File: rtl/ball_vertical_engine.sv
// ball_vertical_engine: ball Y position/velocity with wall reflection and per-line vertical video window
module ball_vertical_engine
    import ball_vertical_engine_pkg::*;
#(
    parameter int V_BITS    = 9,
    parameter int VEL_BITS  = 4,
    parameter int V_TOP     = V_TOP_D,
    parameter int V_BOTTOM  = V_BOTTOM_D,
    parameter int BALL_H    = BALL_H_D,
    parameter int SERVE_Y   = SERVE_Y_D,
    parameter int MAX_SPEED = MAX_SPEED_D
) (
    input  logic                       clk,
    input  logic                       _reset,
    input  logic                       line_ce,
    input  logic                       frame_ce,
    input  logic                       vblank,
    input  logic                       hit,
    input  logic [2:0]                 hit_seg,
    input  logic                       serve,
    input  logic                       attract,
    output logic [V_BITS-1:0]          ball_y,
    output logic signed [VEL_BITS-1:0] vel,
    output logic                       vvid,
    output logic                       _vvid,
    output logic [1:0]                 vball_row,
    output logic                       wall_bounce
);
    localparam int NW = V_BITS + 2;
    localparam logic signed [NW-1:0] TOP_S = NW'(V_TOP);
    localparam logic signed [NW-1:0] BOT_S = NW'(V_BOTTOM - BALL_H);
    logic [V_BITS-1:0] line_cnt, diff, ny;
    logic signed [VEL_BITS-1:0] vel_next, v, nv;
    logic signed [NW-1:0] n, refl_top, refl_bot;
    logic [V_BITS:0] end_y;
    logic pend, lo_hit, hi_hit, in_win;
    ball_vertical_engine_velocity #(.VEL_BITS(VEL_BITS), .MAX_SPEED(MAX_SPEED)) u_vel (
        .clk(clk), ._reset(_reset), .hit(hit), .hit_seg(hit_seg), .attract(attract),
        .frame_ce(frame_ce), .serve(serve), .pend(pend), .vel_next(vel_next)
    );
    always_comb begin
        v        = pend ? vel_next : vel;
        n        = {2'b00, ball_y} + {{(NW-VEL_BITS){v[VEL_BITS-1]}}, v};
        refl_top = (TOP_S <<< 1) - n;
        refl_bot = (BOT_S <<< 1) - n;
        lo_hit   = n < TOP_S;
        hi_hit   = n > BOT_S;
        ny       = lo_hit ? refl_top[V_BITS-1:0] : hi_hit ? refl_bot[V_BITS-1:0] : n[V_BITS-1:0];
        nv       = (lo_hit || hi_hit) ? -v : v;
        end_y    = {1'b0, ball_y} + (V_BITS+1)'(BALL_H);
        diff     = line_cnt - ball_y;
        in_win   = !vblank && line_cnt >= ball_y && {1'b0, line_cnt} < end_y;
    end
    always_ff @(posedge clk) begin
        if (!_reset) begin
            line_cnt    <= '0;
            ball_y      <= V_BITS'(SERVE_Y);
            vel         <= '0;
            vvid        <= 1'b0;
            vball_row   <= '0;
            wall_bounce <= 1'b0;
        end else begin
            line_cnt    <= frame_ce ? '0 : line_ce ? line_cnt + 1'b1 : line_cnt;
            ball_y      <= serve ? V_BITS'(SERVE_Y) : frame_ce ? ny : ball_y;
            vel         <= serve ? (attract ? VEL_BITS'(1) : '0) : frame_ce ? nv : vel;
            wall_bounce <= frame_ce && !serve && (lo_hit || hi_hit);
            vvid        <= in_win;
            vball_row   <= in_win ? diff[1:0] : 2'd0;
        end
    end
    assign _vvid = ~vvid;
endmodule
